// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine datapath blocks.
package vend_pkg;

  localparam int unsigned ItemWDefault = 4;
  localparam int unsigned CntWDefault  = 4;
  // Value of one returned coin in cents; the coin FSM prices in these units.
  localparam int unsigned NickelCents  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDispense,
    StChange,
    StGap,
    StDone,
    StFault
  } vend_state_e;

endpackage

// File: rtl/vend_pulse_spacer.sv
// Loadable down-counter that emits one single-cycle pulse per count, separated
// by NICKEL_GAP idle cycles. The first pulse appears the cycle after load.
module vend_pulse_spacer #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned NICKEL_GAP = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             last_o,
  output logic             gap_end_o
);

  localparam int unsigned GapW = $clog2(NICKEL_GAP + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [GapW-1:0]  gap_q;
  logic             active_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      gap_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= count_i;
      gap_q    <= '0;
      active_q <= (count_i != '0);
    end else if (active_q) begin
      if (gap_q == '0) begin
        // Decrement only while non-zero so the count can never wrap.
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) active_q <= 1'b0;
        else                    gap_q    <= GapW'(NICKEL_GAP);
      end else begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  assign pulse_o   = active_q && (gap_q == '0);
  assign last_o    = pulse_o && (cnt_q <= CNT_W'(1));
  assign gap_end_o = active_q && (gap_q == GapW'(1));

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Post-sale sequencer: runs the item motor with a timeout, then pays change
// (or a refund on empty slot / motor fault) as spaced nickel pulses.
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned ITEM_W        = ItemWDefault,
  parameter int unsigned CNT_W         = CntWDefault,
  parameter int unsigned MOTOR_TIMEOUT = 200,
  parameter int unsigned NICKEL_GAP    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ITEM_W-1:0]    req_item,
  input  logic [CNT_W-1:0]     req_change,
  input  logic [CNT_W-1:0]     req_refund,
  input  logic [2**ITEM_W-1:0] item_empty,
  output logic                 motor_on,
  output logic [ITEM_W-1:0]    motor_sel,
  input  logic                 motor_done,
  output logic                 nickel_out,
  output logic                 dispense,
  output logic                 done,
  output logic                 fault,
  input  logic                 fault_clear
);

  localparam int unsigned TmoW = (MOTOR_TIMEOUT > 2) ? $clog2(MOTOR_TIMEOUT) : 1;

  vend_state_e       state_q;
  logic [ITEM_W-1:0] item_q;
  logic [CNT_W-1:0]  change_q;
  logic [CNT_W-1:0]  refund_q;
  logic [TmoW-1:0]   tmo_q;
  logic              refund_pending_q;
  logic              fault_q;
  logic              motor_on_q;
  logic [ITEM_W-1:0] motor_sel_q;
  logic              done_q;

  logic              slot_empty;
  logic              tmo_hit;
  logic              pay_load;
  logic [CNT_W-1:0]  pay_count;
  logic              pay_pulse;
  logic              pay_last;
  logic              gap_end;

  assign slot_empty = item_empty[item_q];
  assign tmo_hit    = (tmo_q == TmoW'(MOTOR_TIMEOUT - 1));

  // Spacer load requests mirror the transitions into StChange below.
  always_comb begin
    pay_load  = 1'b0;
    pay_count = refund_q;
    case (state_q)
      StCheck:    pay_load = slot_empty && (refund_q != '0);
      StDispense: begin
        pay_load  = motor_done && (change_q != '0);
        pay_count = change_q;
      end
      StFault:    pay_load = refund_pending_q && (refund_q != '0);
      default:    ;
    endcase
  end

  vend_pulse_spacer #(
    .CNT_W      (CNT_W),
    .NICKEL_GAP (NICKEL_GAP)
  ) u_spacer (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (pay_load),
    .count_i   (pay_count),
    .pulse_o   (pay_pulse),
    .last_o    (pay_last),
    .gap_end_o (gap_end)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      item_q           <= '0;
      change_q         <= '0;
      refund_q         <= '0;
      tmo_q            <= '0;
      refund_pending_q <= 1'b0;
      fault_q          <= 1'b0;
      motor_on_q       <= 1'b0;
      motor_sel_q      <= '0;
      done_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            item_q   <= req_item;
            change_q <= req_change;
            refund_q <= req_refund;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          if (slot_empty) begin
            if (refund_q != '0) begin
              state_q <= StChange;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            state_q     <= StDispense;
            motor_on_q  <= 1'b1;
            motor_sel_q <= item_q;
            tmo_q       <= '0;
          end
        end
        StDispense: begin
          // A completion in the final timeout cycle wins over the fault.
          if (motor_done) begin
            motor_on_q  <= 1'b0;
            motor_sel_q <= '0;
            if (change_q != '0) begin
              state_q <= StChange;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
            motor_on_q       <= 1'b0;
            motor_sel_q      <= '0;
            fault_q          <= 1'b1;
            refund_pending_q <= 1'b1;
            state_q          <= StFault;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StChange: begin
          if (pay_last) begin
            if (fault_q) begin
              state_q <= StFault;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_end) state_q <= StChange;
        end
        StFault: begin
          if (refund_pending_q) begin
            refund_pending_q <= 1'b0;
            if (refund_q != '0) state_q <= StChange;
          end else if (fault_clear) begin
            fault_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign motor_on   = motor_on_q;
  assign motor_sel  = motor_sel_q;
  assign nickel_out = pay_pulse;
  assign dispense   = (state_q == StDispense) && motor_done;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Scoreboard bench: stimulus pushes expected pulse events (kind, cycle); a
// negedge monitor pops and compares whenever dispense/nickel_out/done fires.
module tb_vend_dispense_sequencer;

  localparam int KDispense = 0;
  localparam int KNickel   = 1;
  localparam int KDone     = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_item = '0;
  logic [3:0]  req_change = '0;
  logic [3:0]  req_refund = '0;
  logic [15:0] item_empty = '0;
  logic        motor_on;
  logic [3:0]  motor_sel;
  logic        motor_done = 1'b0;
  logic        nickel_out;
  logic        dispense;
  logic        done;
  logic        fault;
  logic        fault_clear = 1'b0;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  motor_cycles = 0;
  int  t;
  ev_t exp_q[$];

  vend_dispense_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_item    (req_item),
    .req_change  (req_change),
    .req_refund  (req_refund),
    .item_empty  (item_empty),
    .motor_on    (motor_on),
    .motor_sel   (motor_sel),
    .motor_done  (motor_done),
    .nickel_out  (nickel_out),
    .dispense    (dispense),
    .done        (done),
    .fault       (fault),
    .fault_clear (fault_clear)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: independent of stimulus, samples away from the rising edge.
  always @(negedge clock) begin
    if (motor_on === 1'b1) motor_cycles++;
    if (dispense === 1'b1)   observe(KDispense);
    if (nickel_out === 1'b1) observe(KNickel);
    if (done === 1'b1)       observe(KDone);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset for two cycles, then release
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_motor_on", 32'(motor_on), 0);
    check("rst_motor_sel", 32'(motor_sel), 0);
    check("rst_nickel_out", 32'(nickel_out), 0);
    check("rst_dispense", 32'(dispense), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);

    // 2: item 1, change 2, motor_done 4 cycles after motor_on rises
    t = cyc;
    req_valid = 1'b1; req_item = 4'd1; req_change = 4'd2; req_refund = 4'd0;
    push(KDispense, t + 6); push(KNickel, t + 7); push(KNickel, t + 11); push(KDone, t + 12);
    step(1);
    req_valid = 1'b0; req_item = 4'd9; req_change = 4'd7;
    check("t2_ready_busy", 32'(req_ready), 0);
    step(1);
    check("t2_motor_on", 32'(motor_on), 1);
    check("t2_motor_sel", 32'(motor_sel), 1);
    step(4);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    check("t2_motor_off", 32'(motor_on), 0);
    step(6);
    check("t2_ready_back", 32'(req_ready), 1);
    check("t2_queue_drained", 32'(exp_q.size()), 0);

    // 3: empty slot 5, refund 3 paid, motor never runs
    t = cyc;
    motor_cycles = 0;
    item_empty = 16'h0020;
    req_valid = 1'b1; req_item = 4'd5; req_change = 4'd1; req_refund = 4'd3;
    push(KNickel, t + 2); push(KNickel, t + 6); push(KNickel, t + 10); push(KDone, t + 11);
    step(1);
    req_valid = 1'b0;
    step(11);
    check("t3_motor_cycles", 32'(motor_cycles), 0);
    check("t3_ready_back", 32'(req_ready), 1);
    check("t3_queue_drained", 32'(exp_q.size()), 0);
    item_empty = '0;

    // 4: item 2, refund 1, motor never completes -> timeout fault
    t = cyc;
    motor_cycles = 0;
    req_valid = 1'b1; req_item = 4'd2; req_change = 4'd3; req_refund = 4'd1;
    push(KNickel, t + 203);
    step(1);
    req_valid = 1'b0;
    step(1);
    check("t4_motor_sel", 32'(motor_sel), 2);
    step(199);
    check("t4_motor_last_cycle", 32'(motor_on), 1);
    check("t4_fault_pre", 32'(fault), 0);
    step(1);
    check("t4_motor_off", 32'(motor_on), 0);
    check("t4_fault_set", 32'(fault), 1);
    step(18);
    check("t4_motor_cycles", 32'(motor_cycles), 200);
    check("t4_fault_held", 32'(fault), 1);
    check("t4_ready_held", 32'(req_ready), 0);
    check("t4_queue_drained", 32'(exp_q.size()), 0);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check("t4_fault_cleared", 32'(fault), 0);
    check("t4_ready_back", 32'(req_ready), 1);

    // 5: change 0 with immediate motor_done; req_valid held through busy
    t = cyc;
    req_valid = 1'b1; req_item = 4'd3; req_change = 4'd0; req_refund = 4'd2;
    push(KDispense, t + 2); push(KDone, t + 3); push(KDispense, t + 6); push(KDone, t + 7);
    step(2);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    check("t5_ready_in_done", 32'(req_ready), 0);
    step(1);
    check("t5_ready_idle", 32'(req_ready), 1);
    step(1);
    req_valid = 1'b0;
    check("t5_second_accepted", 32'(req_ready), 0);
    step(1);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    step(2);
    check("t5_ready_back", 32'(req_ready), 1);
    check("t5_queue_drained", 32'(exp_q.size()), 0);

    // 6: reset in the gap of a 4-nickel payout
    t = cyc;
    req_valid = 1'b1; req_item = 4'd4; req_change = 4'd4; req_refund = 4'd0;
    push(KDispense, t + 2); push(KNickel, t + 3);
    step(1);
    req_valid = 1'b0;
    step(1);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    check("t6_nickel_in_reset", 32'(nickel_out), 0);
    reset = 1'b0;
    step(1);
    check("t6_req_ready", 32'(req_ready), 1);
    check("t6_motor_on", 32'(motor_on), 0);
    check("t6_done", 32'(done), 0);
    check("t6_fault", 32'(fault), 0);
    step(10);
    check("t6_queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
